// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand loader: opcodes, sequential-mode
// selector encoding and load_pulse bit positions.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    SEL_A  = 2'd0,
    SEL_B  = 2'd1,
    SEL_OP = 2'd2
  } sel_e;

  localparam int LP_A  = 2;
  localparam int LP_B  = 1;
  localparam int LP_OP = 0;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Button/switch inputs and latched operand outputs of the operand loader.
// sel_state exists only when ALU_LOADER_SEQ_EN is defined.
interface alu_operand_loader_if #(
  parameter int MSB = 7
) ();

  logic [MSB:0] sw;
  logic         p_a;
  logic         p_b;
  logic         p_c;
  logic [MSB:0] dato_A;
  logic [MSB:0] dato_B;
  logic [5:0]   dato_Op;
  logic [2:0]   load_pulse;
  logic         all_loaded;
`ifdef ALU_LOADER_SEQ_EN
  logic [1:0]   sel_state;
`endif

  modport slave (
    input  sw,
    input  p_a,
    input  p_b,
    input  p_c,
    output dato_A,
    output dato_B,
    output dato_Op,
    output load_pulse,
`ifdef ALU_LOADER_SEQ_EN
    output sel_state,
`endif
    output all_loaded
  );

  modport master (
    output sw,
    output p_a,
    output p_b,
    output p_c,
    input  dato_A,
    input  dato_B,
    input  dato_Op,
    input  load_pulse,
`ifdef ALU_LOADER_SEQ_EN
    input  sel_state,
`endif
    input  all_loaded
  );

endinterface

// File: rtl/alu_btn_debounce.sv
// One pushbutton: 2-FF synchronizer, counter-based debounce and a registered
// one-clock press strobe on each rising edge of the debounced level.
module alu_btn_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stablePrev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The level is accepted only after it has differed for DEB_CYCLES clocks in a row.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stablePrev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stablePrev_q <= stable_q;
      press_q      <= stable_q & ~stablePrev_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Latches synchronized switches into A/B/Op on clean button presses.
// Define ALU_LOADER_SEQ_EN for single-button sequential A -> B -> Op mode.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int MSB        = 7,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 20
) (
  input logic                 clk,
  input logic                 reset,
  alu_operand_loader_if.slave bus
);

  logic [MSB:0] swSync1_q;
  logic [MSB:0] swSync2_q;
  logic [MSB:0] datoA_q;
  logic [MSB:0] datoB_q;
  logic [5:0]   datoOp_q;
  logic [2:0]   loadPulse_q;
  logic [2:0]   loadSel_d;
  logic [2:0]   loaded_q;
  logic         allLoaded_q;
  logic         pressA;

  alu_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_a (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.p_a),
    .press_o(pressA)
  );

`ifdef ALU_LOADER_SEQ_EN
  sel_e state_q;
  sel_e state_d;
  logic unusedBtns;

  assign unusedBtns = bus.p_b ^ bus.p_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEL_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Each press loads the currently selected register and moves to the next one.
  always_comb begin
    state_d   = state_q;
    loadSel_d = 3'b000;
    if (pressA) begin
      case (state_q)
        SEL_A: begin
          loadSel_d[LP_A] = 1'b1;
          state_d         = SEL_B;
        end
        SEL_B: begin
          loadSel_d[LP_B] = 1'b1;
          state_d         = SEL_OP;
        end
        SEL_OP: begin
          loadSel_d[LP_OP] = 1'b1;
          state_d          = SEL_A;
        end
        default: begin
          state_d = SEL_A;
        end
      endcase
    end
  end

  assign bus.sel_state = state_q;
`else
  logic pressB;
  logic pressC;

  alu_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_b (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.p_b),
    .press_o(pressB)
  );

  alu_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_c (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.p_c),
    .press_o(pressC)
  );

  // Fixed priority A > B > Op; dropped presses are not remembered.
  always_comb begin
    loadSel_d = 3'b000;
    if (pressA) begin
      loadSel_d[LP_A] = 1'b1;
    end else if (pressB) begin
      loadSel_d[LP_B] = 1'b1;
    end else if (pressC) begin
      loadSel_d[LP_OP] = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      swSync1_q   <= '0;
      swSync2_q   <= '0;
      datoA_q     <= '0;
      datoB_q     <= '0;
      datoOp_q    <= '0;
      loadPulse_q <= '0;
      loaded_q    <= '0;
      allLoaded_q <= 1'b0;
    end else begin
      swSync1_q   <= bus.sw;
      swSync2_q   <= swSync1_q;
      loadPulse_q <= loadSel_d;
      loaded_q    <= loaded_q | loadSel_d;
      allLoaded_q <= allLoaded_q | (&loaded_q);
      if (loadSel_d[LP_A]) begin
        datoA_q <= swSync2_q;
      end
      if (loadSel_d[LP_B]) begin
        datoB_q <= swSync2_q;
      end
      if (loadSel_d[LP_OP]) begin
        datoOp_q <= swSync2_q[5:0];
      end
    end
  end

  assign bus.dato_A     = datoA_q;
  assign bus.dato_B     = datoB_q;
  assign bus.dato_Op    = datoOp_q;
  assign bus.load_pulse = loadPulse_q;
  assign bus.all_loaded = allLoaded_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader (DEB_CYCLES=4); covers the sequential
// mode instead of the three-button tests when ALU_LOADER_SEQ_EN is defined.
module tb_alu_operand_loader;

  logic clk;
  logic reset;
  int   testCount;
  int   failCount;
  int   cntA;
  int   cntB;
  int   cntOp;

  alu_operand_loader_if #(.MSB(7)) bus ();

  alu_operand_loader #(
    .MSB       (7),
    .DEB_CYCLES(4),
    .CNT_W     (20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic nextCycle();
    @(negedge clk);
    if (bus.load_pulse[2]) cntA++;
    if (bus.load_pulse[1]) cntB++;
    if (bus.load_pulse[0]) cntOp++;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  task automatic applyStimulus(input logic pa, input logic pb, input logic pc, input logic [7:0] swVal);
    bus.p_a = pa;
    bus.p_b = pb;
    bus.p_c = pc;
    bus.sw  = swVal;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pressButton(input int which, input logic [7:0] swVal);
    applyStimulus(1'b0, 1'b0, 1'b0, swVal);
    waitCycles(3);
    applyStimulus(which == 0, which == 1, which == 2, swVal);
    waitCycles(12);
    applyStimulus(1'b0, 1'b0, 1'b0, swVal);
    waitCycles(10);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    cntA = 0;
    cntB = 0;
    cntOp = 0;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);

    waitCycles(3);
    checkOutput("rst_dato_A", 32'(bus.dato_A), 32'h00);
    checkOutput("rst_dato_B", 32'(bus.dato_B), 32'h00);
    checkOutput("rst_dato_Op", 32'(bus.dato_Op), 32'h00);
    checkOutput("rst_load_pulse", 32'(bus.load_pulse), 32'h0);
    checkOutput("rst_all_loaded", 32'(bus.all_loaded), 32'h0);

    reset = 1'b0;
    waitCycles(7);
    checkOutput("post_rst_early_A", 32'(bus.dato_A), 32'h00);
    checkOutput("post_rst_early_pulse", 32'(bus.load_pulse), 32'h0);
    waitCycles(1);
    checkOutput("post_rst_dato_A", 32'(bus.dato_A), 32'hFF);
    checkOutput("post_rst_pulse", 32'(bus.load_pulse), 32'b100);
    waitCycles(1);
    checkOutput("post_rst_pulse_end", 32'(bus.load_pulse), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
    waitCycles(10);

`ifdef ALU_LOADER_SEQ_EN
    checkOutput("seq_after_first", 32'(bus.sel_state), 32'd1);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    checkOutput("seq_rst_state", 32'(bus.sel_state), 32'd0);
    checkOutput("seq_rst_A", 32'(bus.dato_A), 32'h00);
    pressButton(0, 8'h11);
    checkOutput("seq1_A", 32'(bus.dato_A), 32'h11);
    checkOutput("seq1_state", 32'(bus.sel_state), 32'd1);
    pressButton(0, 8'h22);
    checkOutput("seq2_B", 32'(bus.dato_B), 32'h22);
    checkOutput("seq2_state", 32'(bus.sel_state), 32'd2);
    pressButton(0, 8'h20);
    checkOutput("seq3_Op", 32'(bus.dato_Op), 32'h20);
    checkOutput("seq3_state", 32'(bus.sel_state), 32'd0);
    checkOutput("seq3_all_loaded", 32'(bus.all_loaded), 32'h1);
    pressButton(0, 8'h33);
    checkOutput("seq4_A", 32'(bus.dato_A), 32'h33);
    checkOutput("seq4_B", 32'(bus.dato_B), 32'h22);
    checkOutput("seq4_Op", 32'(bus.dato_Op), 32'h20);
    checkOutput("seq4_state", 32'(bus.sel_state), 32'd1);
`else
    // Bounce on p_b: high pulses of two clocks must never be accepted.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h3C);
    waitCycles(3);
    cntB = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, 1'b0, 8'h3C);
      waitCycles(2);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C);
    waitCycles(7);
    checkOutput("bounce_no_early_pulse", 32'(cntB), 32'd0);
    checkOutput("bounce_B_unchanged", 32'(bus.dato_B), 32'h00);
    waitCycles(1);
    checkOutput("bounce_dato_B", 32'(bus.dato_B), 32'h3C);
    checkOutput("bounce_pulse", 32'(bus.load_pulse), 32'b010);
    waitCycles(20);
    checkOutput("bounce_single_load", 32'(cntB), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h3C);
    waitCycles(10);

    pressButton(0, 8'h05);
    checkOutput("seq_dato_A", 32'(bus.dato_A), 32'h05);
    checkOutput("seq_not_all_1", 32'(bus.all_loaded), 32'h0);
    pressButton(1, 8'hFD);
    checkOutput("seq_dato_B", 32'(bus.dato_B), 32'hFD);
    checkOutput("seq_not_all_2", 32'(bus.all_loaded), 32'h0);
    pressButton(2, 8'h22);
    checkOutput("seq_dato_Op", 32'(bus.dato_Op), 32'h22);
    checkOutput("seq_all_loaded", 32'(bus.all_loaded), 32'h1);
    checkOutput("seq_A_kept", 32'(bus.dato_A), 32'h05);

    // p_a and p_c together: only A loads.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h2A);
    waitCycles(3);
    cntA = 0;
    cntOp = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h2A);
    waitCycles(7);
    checkOutput("simul_early_pulse", 32'(bus.load_pulse), 32'h0);
    waitCycles(1);
    checkOutput("simul_dato_A", 32'(bus.dato_A), 32'h2A);
    checkOutput("simul_pulse", 32'(bus.load_pulse), 32'b100);
    waitCycles(10);
    checkOutput("simul_Op_kept", 32'(bus.dato_Op), 32'h22);
    checkOutput("simul_cntA", 32'(cntA), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h2A);
    waitCycles(20);
    checkOutput("simul_no_late_Op", 32'(cntOp), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h25);
    waitCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h25);
    waitCycles(12);
    checkOutput("repress_dato_Op", 32'(bus.dato_Op), 32'h25);
    checkOutput("repress_cntOp", 32'(cntOp), 32'd1);

    // p_c held for 100 clocks with sw changing underneath.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h26);
    waitCycles(10);
    cntOp = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h26);
    waitCycles(10);
    checkOutput("hold_dato_Op", 32'(bus.dato_Op), 32'h26);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
    waitCycles(90);
    checkOutput("hold_single_load", 32'(cntOp), 32'd1);
    checkOutput("hold_Op_kept", 32'(bus.dato_Op), 32'h26);
    checkOutput("hold_A_kept", 32'(bus.dato_A), 32'h2A);
    checkOutput("hold_all_loaded", 32'(bus.all_loaded), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h01);
    waitCycles(10);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
